// File: rtl/intra_pred_pkg.sv
// Shared types for the intra-prediction index aux path: mode constants,
// the intraPredAngle lookup, sequencer state and the beat carried downstream.
package intra_pred_pkg;

    localparam logic [5:0] PLANAR   = 6'd0;
    localparam logic [5:0] DC       = 6'd1;
    localparam logic [5:0] HOR      = 6'd10;
    localparam logic [5:0] VER      = 6'd26;
    localparam logic [5:0] MAX_MODE = 6'd34;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       bypass;
        logic       neg;
        logic [2:0] abs_sel;
    } angle_t;

    typedef struct packed {
        logic [4:0]      row;
        logic [3:0][7:0] aux;
        logic            bypass;
        logic            vertical;
        logic            last;
    } beat_t;

    // abs_sel orders |angle| as 2,5,9,13,17,21,26,32; zero-angle and
    // non-angular modes come back as bypass.
    function automatic angle_t mode_angle(input logic [5:0] mode);
        angle_t a;
        a.bypass  = 1'b1;
        a.neg     = 1'b0;
        a.abs_sel = 3'd0;
        if (mode >= 6'd2 && mode <= 6'd9) begin
            a.bypass  = 1'b0;
            a.abs_sel = 3'(6'd9 - mode);
        end else if (mode >= 6'd11 && mode <= 6'd18) begin
            a.bypass  = 1'b0;
            a.neg     = 1'b1;
            a.abs_sel = 3'(mode - 6'd11);
        end else if (mode >= 6'd19 && mode <= 6'd25) begin
            a.bypass  = 1'b0;
            a.neg     = 1'b1;
            a.abs_sel = 3'(6'd25 - mode);
        end else if (mode >= 6'd27 && mode <= MAX_MODE) begin
            a.bypass  = 1'b0;
            a.abs_sel = 3'(mode - 6'd27);
        end
        return a;
    endfunction

endpackage

// File: rtl/index_aux_beat_fifo.sv
// Small synchronous FIFO of beat_t used to realign LUT returns with row
// metadata; exposes occupancy for the issuer's credit check.
module index_aux_beat_fifo
    import intra_pred_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  beat_t         i_data,
    input  logic          i_pop,
    output beat_t         o_head,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t         r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr, w_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd = i_pop && (r_count != '0);
    assign w_wr = i_push && ((r_count != CW'(DEPTH)) || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= nxt(r_wptr);
            end
            if (w_rd) r_rptr <= nxt(r_rptr);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/index_aux_addr_gen.sv
// Row sequencer for the intra index aux LUT: issues one read per row, realigns
// returns and streams beats downstream. Optional INDEX_AUX_PERF_EN adds o_stall_cnt.
module index_aux_addr_gen
    import intra_pred_pkg::*;
#(
    parameter int LUT_LATENCY = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [5:0] i_mode,
    input  logic [2:0] i_log2_size,
    output logic       o_busy,
    output logic       o_lut_rden,
    output logic [8:0] o_lut_addr,
    input  logic [7:0] i_lut_q1,
    input  logic [7:0] i_lut_q2,
    input  logic [7:0] i_lut_q3,
    input  logic [7:0] i_lut_q4,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [4:0] o_out_row,
    output logic [7:0] o_out_aux1,
    output logic [7:0] o_out_aux2,
    output logic [7:0] o_out_aux3,
    output logic [7:0] o_out_aux4,
    output logic       o_out_bypass,
    output logic       o_out_vertical,
    output logic       o_out_last,
    output logic       o_done
`ifdef INDEX_AUX_PERF_EN
   ,output logic [15:0] o_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef logic [LUT_LATENCY-1:0]      vld_pipe_t;
    typedef logic [LUT_LATENCY-1:0][4:0] row_pipe_t;

    state_t    r_state, w_state_nxt;
    angle_t    r_ang;
    logic      r_vert, r_done;
    logic [4:0] r_row, r_last_row;
    logic [8:0] r_lut_addr;
    vld_pipe_t r_vld_pipe;
    row_pipe_t r_row_pipe;

    logic [5:0]    w_mode_eff;
    logic [2:0]    w_size;
    logic [4:0]    w_last_row;
    logic [8:0]    w_addr;
    logic [7:0]    w_infl;
    logic [CW-1:0] w_occ;
    logic          w_start_acc, w_credit, w_issue, w_issue_rd, w_pop, w_push, w_empty, w_done_nxt;
    beat_t         w_head, w_push_beat;

    // Out-of-range modes behave exactly like DC, including the vertical flag.
    assign w_mode_eff  = (i_mode > MAX_MODE) ? DC : i_mode;
    assign w_size      = (i_log2_size < 3'd2) ? 3'd2 : (i_log2_size > 3'd5) ? 3'd5 : i_log2_size;
    assign w_last_row  = 5'((6'd1 << w_size) - 6'd1);
    assign w_start_acc = i_start && (r_state == IDLE);
    assign w_addr      = {r_ang.neg, r_ang.abs_sel, r_row};
    assign w_pop       = !w_empty && i_out_ready;

    always_comb begin
        w_infl = '0;
        for (int i = 0; i < LUT_LATENCY; i++) w_infl = w_infl + {7'd0, r_vld_pipe[i]};
    end

    // A beat leaving this cycle frees its slot in time for a new read,
    // which keeps the stream bubble-free with out_ready held high.
    assign w_credit   = ({1'b0, w_infl} + 9'(w_occ)) < (9'(FIFO_DEPTH) + {8'd0, w_pop});
    assign w_issue    = (r_state == ISSUE) && w_credit;
    assign w_issue_rd = w_issue && !r_ang.bypass;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue && (r_row == r_last_row)) w_state_nxt = DRAIN;
            DRAIN:   if (w_pop && w_head.last) begin
                         w_state_nxt = IDLE;
                         w_done_nxt  = 1'b1;
                     end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_push_beat          = '0;
        w_push_beat.vertical = r_vert;
        if (r_vld_pipe[LUT_LATENCY-1]) begin
            w_push_beat.row  = r_row_pipe[LUT_LATENCY-1];
            w_push_beat.aux  = {i_lut_q4, i_lut_q3, i_lut_q2, i_lut_q1};
            w_push_beat.last = (r_row_pipe[LUT_LATENCY-1] == r_last_row);
        end else begin
            w_push_beat.row    = r_row;
            w_push_beat.bypass = 1'b1;
            w_push_beat.last   = (r_row == r_last_row);
        end
    end
    assign w_push = r_vld_pipe[LUT_LATENCY-1] || (w_issue && r_ang.bypass);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ang      <= '0;
            r_vert     <= 1'b0;
            r_row      <= '0;
            r_last_row <= '0;
            r_lut_addr <= '0;
            r_vld_pipe <= '0;
            r_row_pipe <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_start_acc) begin
                r_ang      <= mode_angle(w_mode_eff);
                r_vert     <= (w_mode_eff >= 6'd18);
                r_row      <= '0;
                r_last_row <= w_last_row;
            end else if (w_issue) begin
                r_row <= r_row + 1'b1;
            end
            if (w_issue_rd) r_lut_addr <= w_addr;
            r_vld_pipe <= vld_pipe_t'({r_vld_pipe, w_issue_rd});
            r_row_pipe <= row_pipe_t'({r_row_pipe, r_row});
        end
    end

    index_aux_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_beat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign o_busy         = (r_state != IDLE);
    assign o_lut_rden     = w_issue_rd;
    assign o_lut_addr     = w_issue_rd ? w_addr : r_lut_addr;
    assign o_out_valid    = !w_empty;
    assign o_out_row      = w_head.row;
    assign o_out_aux1     = w_head.aux[0];
    assign o_out_aux2     = w_head.aux[1];
    assign o_out_aux3     = w_head.aux[2];
    assign o_out_aux4     = w_head.aux[3];
    assign o_out_bypass   = w_head.bypass;
    assign o_out_vertical = w_head.vertical;
    assign o_out_last     = w_head.last;
    assign o_done         = r_done;

`ifdef INDEX_AUX_PERF_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_stall_cnt <= '0;
        else if (w_start_acc)                          r_stall_cnt <= '0;
        else if (!w_empty && !i_out_ready && (r_stall_cnt != 16'hFFFF))
                                                       r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_index_aux_addr_gen.sv
// Scoreboard bench for index_aux_addr_gen: directed blocks push expected
// addresses/beats; a negedge monitor pops and compares what the DUT presents.
module tb_index_aux_addr_gen;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0] row;
        logic [7:0] a1, a2, a3, a4;
        logic       byp, vert, last;
    } tbb_t;

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [5:0] mode = '0;
    logic [2:0] lsz = '0;
    logic [7:0] q1 = '0, q2 = '0, q3 = '0, q4 = '0;
    logic       busy, lut_rden, out_valid, out_bypass, out_vertical, out_last, done;
    logic [8:0] lut_addr;
    logic [4:0] out_row;
    logic [7:0] aux1, aux2, aux3, aux4;

    tbb_t       exp_q[$];
    logic [8:0] addr_q[$];
    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, done_cyc = 0, acc = 0;
    int rd_iss = 0, rd_acc = 0;
    bit done_pend = 0, stall_prev = 0, rnd_en = 0;

    always #5 clk = ~clk;

    index_aux_addr_gen dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_mode(mode), .i_log2_size(lsz),
        .o_busy(busy), .o_lut_rden(lut_rden), .o_lut_addr(lut_addr),
        .i_lut_q1(q1), .i_lut_q2(q2), .i_lut_q3(q3), .i_lut_q4(q4),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_row(out_row),
        .o_out_aux1(aux1), .o_out_aux2(aux2), .o_out_aux3(aux3), .o_out_aux4(aux4),
        .o_out_bypass(out_bypass), .o_out_vertical(out_vertical), .o_out_last(out_last),
        .o_done(done)
    );

    function automatic logic [7:0] lut_val(input logic [8:0] a, input int k);
        return (a[7:0] + 8'(37 * k)) ^ {a[8], 7'd0};
    endfunction

    // LUT bank model, one cycle read latency
    always @(posedge clk) if (lut_rden) begin
        q1 <= lut_val(lut_addr, 1);
        q2 <= lut_val(lut_addr, 2);
        q3 <= lut_val(lut_addr, 3);
        q4 <= lut_val(lut_addr, 4);
    end

    initial forever begin
        @(posedge clk);
        #1 if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        tbb_t act, e;
        logic [8:0] ea;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            rd_iss = 0; rd_acc = 0;
            done_pend = 0; stall_prev = 0;
        end else begin
            if (done || done_pend) chk(done == done_pend, "done_pulse", done, done_pend);
            if (done) begin done_cnt++; done_cyc = cyc; end
            done_pend = 0;
            if (stall_prev) chk(out_valid, "stall_valid_drop", out_valid, 1);
            if (lut_rden) begin
                rd_iss++;
                if (addr_q.size() == 0) chk(0, "unexpected_read", lut_addr, 0);
                else begin
                    ea = addr_q.pop_front();
                    chk(lut_addr == ea, "lut_addr", lut_addr, ea);
                end
            end
            if (out_valid) begin
                act = '{out_row, aux1, aux2, aux3, aux4, out_bypass, out_vertical, out_last};
                if (exp_q.size() == 0) chk(0, "unexpected_beat", act, 0);
                else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk(act == e, "beat", act, e);
                    if (e.last) done_pend = 1;
                    if (!e.byp) rd_acc++;
                    acc++;
                end else begin
                    chk(act == exp_q[0], "stall_hold", act, exp_q[0]);
                end
            end
            if (lut_rden) chk(rd_iss - rd_acc <= DEPTH, "credit", rd_iss - rd_acc, DEPTH);
            stall_prev = out_valid && !out_ready;
        end
    end

    task automatic run_block(input logic [5:0] m, input logic [2:0] sz, input int n,
                             input bit neg, input logic [2:0] abs_sel, input bit byp, input bit vert,
                             input int lat, input bit rnd, input bit dbl, input int abort_after);
        tbb_t e;
        logic [8:0] a;
        int s, d0, a0;
        for (int r = 0; r < n; r++) begin
            a      = {neg, abs_sel, 5'(r)};
            e.row  = 5'(r);
            e.a1   = byp ? 8'd0 : lut_val(a, 1);
            e.a2   = byp ? 8'd0 : lut_val(a, 2);
            e.a3   = byp ? 8'd0 : lut_val(a, 3);
            e.a4   = byp ? 8'd0 : lut_val(a, 4);
            e.byp  = byp;
            e.vert = vert;
            e.last = (r == n - 1);
            exp_q.push_back(e);
            if (!byp) addr_q.push_back(a);
        end
        d0 = done_cnt;
        a0 = acc;
        @(posedge clk);
        #1 mode = m; lsz = sz; start = 1'b1; out_ready = 1'b1; rnd_en = rnd;
        @(posedge clk);
        #1 start = 1'b0;
        s = cyc;
        chk(busy == 1'b1, "busy_set", busy, 1);
        if (dbl) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1; mode = 6'd2; lsz = 3'd2;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (abort_after > 0) begin
            for (int i = 0; i < 300 && (acc - a0) < abort_after; i++) @(posedge clk);
            #1 rst_n = 1'b0;
            #1 chk({busy, lut_rden, out_valid, done, out_bypass, out_vertical, out_last,
                    lut_addr, out_row, aux1, aux2, aux3, aux4} == '0, "mid_reset_clear",
                   {busy, lut_rden, out_valid, done, out_bypass, out_vertical, out_last,
                    lut_addr, out_row, aux1, aux2, aux3, aux4}, 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1; rnd_en = 0; out_ready = 1'b1;
            return;
        end
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(posedge clk);
        rnd_en = 0;
        #1 out_ready = 1'b1;
        chk(done_cnt != d0, "done_timeout", done_cnt - d0, 1);
        if (lat > 0) chk(done_cyc - s == lat, "latency", done_cyc - s, lat);
        repeat (3) @(posedge clk);
        #1 chk(exp_q.size() == 0 && addr_q.size() == 0, "leftover", exp_q.size() + addr_q.size(), 0);
        chk(busy == 1'b0 && out_valid == 1'b0, "idle_after", {busy, out_valid}, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 chk({busy, lut_rden, out_valid, done, out_bypass, out_vertical, out_last,
                lut_addr, out_row, aux1, aux2, aux3, aux4} == '0, "reset_state",
               {busy, lut_rden, out_valid, done, out_bypass, out_vertical, out_last,
                lut_addr, out_row, aux1, aux2, aux3, aux4}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        //        mode    sz    n  neg abs byp vrt lat rnd dbl abort
        run_block(6'd2,  3'd2,  4, 0, 3'd7, 0, 0,  7, 0, 0, 0);
        run_block(6'd18, 3'd5, 32, 1, 3'd7, 0, 1, 35, 0, 0, 0);
        run_block(6'd26, 3'd3,  8, 0, 3'd0, 1, 1, 10, 0, 0, 0);
        run_block(6'd0,  3'd3,  8, 0, 3'd0, 1, 0, 10, 0, 0, 0);
        run_block(6'd3,  3'd0,  4, 0, 3'd6, 0, 0,  7, 0, 0, 0);
        run_block(6'd11, 3'd4, 16, 1, 3'd0, 0, 0,  0, 1, 0, 0);
        run_block(6'd11, 3'd4, 16, 1, 3'd0, 0, 0,  0, 0, 0, 6);
        run_block(6'd27, 3'd2,  4, 0, 3'd0, 0, 1,  7, 0, 0, 0);
        run_block(6'd40, 3'd7, 32, 0, 3'd0, 1, 0, 34, 0, 1, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
